// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmit/receive slice.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_FLUSH
  } rx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit timer: wraps to 0 after CLK_PER_BIT-1, loadable for phase alignment.
module uart_baud_counter #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load,
  input  logic [$clog2(CLK_PER_BIT):0]  i_load_val,
  output logic                          o_tc
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT) + 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tc = (r_cnt == CNT_W'(CLK_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART with independent TX and RX paths; RX samples a 2-FF synchronised line at mid-bit.
module uart_txrx #(
  parameter int unsigned CLK_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_ready,
  output logic       tx_done,
  output logic       tx_serial,
  input  logic       rx_serial,
  output logic       rx_ready,
  output logic [7:0] rx_data
);

  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] ZERO_LOAD = '0;
  // Loading this value makes the counter reach terminal count after CLK_PER_BIT/2 cycles.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_BIT - CLK_PER_BIT / 2);

  tx_state_t            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [2:0]           r_tx_idx;
  logic                 r_tx_serial;
  logic                 r_tx_done;
  logic                 w_tx_load;
  logic                 w_tx_tc;

  rx_state_t            r_rx_state;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [2:0]           r_rx_idx;
  logic                 r_rx_stop_ok;
  logic                 r_rx_ready;
  logic [7:0]           r_rx_data;
  logic                 w_rx_load;
  logic                 w_rx_tc;

  assign tx_serial = r_tx_serial;
  assign tx_done   = r_tx_done;
  assign rx_ready  = r_rx_ready;
  assign rx_data   = r_rx_data;

  assign w_tx_load = (r_tx_state == TX_IDLE);

  // A good stop sample reloads the timer so the strobe lands at the end of the stop bit.
  assign w_rx_load = (r_rx_state == RX_IDLE) ||
                     ((r_rx_state == RX_STOP) && w_rx_tc && !r_rx_stop_ok && r_rx_sync);

  uart_baud_counter #(.CLK_PER_BIT(CLK_PER_BIT)) u_tx_baud (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tx_load),
    .i_load_val (ZERO_LOAD),
    .o_tc       (w_tx_tc)
  );

  uart_baud_counter #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx_baud (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_rx_load),
    .i_load_val (HALF_LOAD),
    .o_tc       (w_rx_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= TX_IDLE;
      r_tx_shift  <= '0;
      r_tx_idx    <= '0;
      r_tx_serial <= 1'b1;
      r_tx_done   <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (tx_data_ready) begin
            r_tx_shift  <= tx_data;
            r_tx_serial <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_tc) begin
            r_tx_serial <= r_tx_shift[0];
            r_tx_idx    <= '0;
            r_tx_state  <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tc) begin
            if (r_tx_idx == LAST_BIT) begin
              r_tx_serial <= 1'b1;
              r_tx_state  <= TX_STOP;
            end else begin
              r_tx_shift  <= r_tx_shift >> 1;
              r_tx_serial <= r_tx_shift[1];
              r_tx_idx    <= r_tx_idx + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tx_tc) begin
            r_tx_done  <= 1'b1;
            r_tx_state <= TX_IDLE;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_serial;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_rx_shift   <= '0;
      r_rx_idx     <= '0;
      r_rx_stop_ok <= 1'b0;
      r_rx_ready   <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      r_rx_ready <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (!r_rx_sync) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (w_rx_tc) begin
            if (r_rx_sync) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_idx   <= '0;
              r_rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_tc) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == LAST_BIT) begin
              r_rx_stop_ok <= 1'b0;
              r_rx_state   <= RX_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (w_rx_tc) begin
            if (r_rx_stop_ok) begin
              r_rx_data  <= r_rx_shift;
              r_rx_ready <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else if (r_rx_sync) begin
              r_rx_stop_ok <= 1'b1;
            end else begin
              r_rx_state <= RX_FLUSH;
            end
          end
        end
        RX_FLUSH: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench: waveform probes and RX error cases at 100 clk/bit, full byte sweep at 4 clk/bit.
module tb_uart_txrx;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_done;
  logic       tx_serial;
  logic       rx_serial;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       loop_en;
  logic       bench_rx;

  logic [7:0] f_tx_data;
  logic       f_tx_data_ready;
  logic       f_tx_done;
  logic       f_tx_serial;
  logic       f_rx_ready;
  logic [7:0] f_rx_data;

  int n_assert = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;

  assign rx_serial = loop_en ? tx_serial : bench_rx;

  uart_txrx #(.CLK_PER_BIT(100)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_done       (tx_done),
    .tx_serial     (tx_serial),
    .rx_serial     (rx_serial),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data)
  );

  uart_txrx #(.CLK_PER_BIT(4)) dut_fast (
    .clk           (clk),
    .rst           (rst),
    .tx_data       (f_tx_data),
    .tx_data_ready (f_tx_data_ready),
    .tx_done       (f_tx_done),
    .tx_serial     (f_tx_serial),
    .rx_serial     (f_tx_serial),
    .rx_ready      (f_rx_ready),
    .rx_data       (f_rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rx_ready) rx_cnt <= rx_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rx(input int base, input int limit, output logic got);
    got = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      @(negedge clk);
      if (rx_cnt > base) got = 1'b1;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    bench_rx = 1'b0;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bench_rx = b[i];
      repeat (100) @(negedge clk);
    end
    bench_rx = stop_bit;
    repeat (100) @(negedge clk);
    bench_rx = 1'b1;
  endtask

  // frame[k] is the expected line level during bit period k (k=0 start, k=9 stop).
  task automatic probe_frame(input logic [7:0] b, input logic [9:0] frame, input string tag);
    int low;
    tx_data       = b;
    tx_data_ready = 1'b1;
    @(negedge clk);
    tx_data_ready = 1'b0;
    low = 0;
    for (int c = 0; c <= 1000; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 1000 && ((c % 100) == 0 || (c % 100) == 50 || (c % 100) == 99))
        check($sformatf("%s_bit%0d_c%0d", tag, c / 100, c % 100), 32'(tx_serial), 32'(frame[c / 100]));
      if (!tx_done) low++;
    end
    check({tag, "_done_low_cycles"}, low, 1000);
    check({tag, "_done_after"}, 32'(tx_done), 1);
  endtask

  initial begin
    logic got;
    int   base;
    int   low;
    int   falls;
    logic prev;

    rst             = 1'b1;
    tx_data         = '0;
    tx_data_ready   = 1'b0;
    loop_en         = 1'b1;
    bench_rx        = 1'b1;
    f_tx_data       = '0;
    f_tx_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial), 1);
    check("rst_tx_done", 32'(tx_done), 1);
    check("rst_rx_ready", 32'(rx_ready), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_fast_tx_done", 32'(f_tx_done), 1);
    check("rst_fast_rx_data", 32'(f_rx_data), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int b = 0; b < 256; b++) begin
      f_tx_data       = 8'(b);
      f_tx_data_ready = 1'b1;
      @(negedge clk);
      f_tx_data_ready = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        if (f_rx_ready) got = 1'b1;
      end
      check($sformatf("sweep_seen_%02h", b), 32'(got), 1);
      check($sformatf("sweep_data_%02h", b), 32'(f_rx_data), 32'(b));
      check($sformatf("sweep_txdone_%02h", b), 32'(f_tx_done), 1);
    end

    base = rx_cnt;
    probe_frame(8'h63, 10'b1011000110, "tx63");
    wait_rx(base, 100, got);
    check("loop63_seen", 32'(got), 1);
    check("loop63_data", 32'(rx_data), 32'h63);
    check("loop63_txdone", 32'(tx_done), 1);
    repeat (5) @(negedge clk);

    base  = rx_cnt;
    falls = 0;
    low   = 0;
    prev  = tx_done;
    tx_data       = 8'h5A;
    tx_data_ready = 1'b1;
    for (int c = 0; c < 1300; c++) begin
      @(negedge clk);
      if (c == 2) tx_data_ready = 1'b0;
      if (prev && !tx_done) falls++;
      prev = tx_done;
      if (!tx_done) low++;
    end
    check("hold3_frames", falls, 1);
    check("hold3_done_low_cycles", low, 1000);
    check("hold3_rx_pulses", rx_cnt - base, 1);
    check("hold3_rx_data", 32'(rx_data), 32'h5A);

    bench_rx = 1'b1;
    loop_en  = 1'b0;
    repeat (5) @(negedge clk);
    base = rx_cnt;
    bench_rx = 1'b0;
    repeat (20) @(negedge clk);
    bench_rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_no_strobe", rx_cnt - base, 0);
    check("glitch_data_kept", 32'(rx_data), 32'h5A);
    drive_rx(8'h81, 1'b1);
    wait_rx(base, 200, got);
    check("post_glitch_seen", 32'(got), 1);
    check("post_glitch_data", 32'(rx_data), 32'h81);

    base = rx_cnt;
    drive_rx(8'hA5, 1'b0);
    repeat (300) @(negedge clk);
    check("framing_no_strobe", rx_cnt - base, 0);
    check("framing_data_kept", 32'(rx_data), 32'h81);
    drive_rx(8'h3C, 1'b1);
    wait_rx(base, 200, got);
    check("recover_seen", 32'(got), 1);
    check("recover_data", 32'(rx_data), 32'h3C);
    repeat (5) @(negedge clk);
    check("recover_one_strobe", rx_cnt - base, 1);

    loop_en       = 1'b1;
    repeat (5) @(negedge clk);
    tx_data       = 8'h00;
    tx_data_ready = 1'b1;
    @(negedge clk);
    tx_data_ready = 1'b0;
    repeat (350) @(negedge clk);
    check("midframe_line_low", 32'(tx_serial), 0);
    check("midframe_busy", 32'(tx_done), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx_serial", 32'(tx_serial), 1);
    check("abort_tx_done", 32'(tx_done), 1);
    check("abort_rx_ready", 32'(rx_ready), 0);
    check("abort_rx_data", 32'(rx_data), 0);
    repeat (5) @(negedge clk);
    base = rx_cnt;
    probe_frame(8'hC3, 10'b1110000110, "txC3");
    wait_rx(base, 100, got);
    check("loopC3_seen", 32'(got), 1);
    check("loopC3_data", 32'(rx_data), 32'hC3);
    check("loopC3_txdone", 32'(tx_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
